// File: rtl/pe_core_pkg.sv
// ============================================================================
// Module : pe_core_pkg
// Brief  : Shared opcode/func encodings and datapath width for the PE core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pe_core_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_ARITH = 7'h01;
    localparam logic [6:0] OPC_FPU   = 7'h02;
    localparam logic [6:0] OPC_CMP   = 7'h10;

    // ARITH class
    localparam logic [4:0] FN_ADD  = 5'd1;
    localparam logic [4:0] FN_SUB  = 5'd2;
    localparam logic [4:0] FN_MUL  = 5'd3;
    localparam logic [4:0] FN_DIV  = 5'd4;
    localparam logic [4:0] FN_MAD  = 5'd5;
    localparam logic [4:0] FN_AND  = 5'd9;
    localparam logic [4:0] FN_OR   = 5'd10;
    localparam logic [4:0] FN_XOR  = 5'd11;
    localparam logic [4:0] FN_SHL  = 5'd12;
    localparam logic [4:0] FN_SHR  = 5'd13;

    // FPU class (signed integer semantics)
    localparam logic [4:0] FN_FMA  = 5'd1;
    localparam logic [4:0] FN_RELU = 5'd11;
    localparam logic [4:0] FN_ABS  = 5'd13;
    localparam logic [4:0] FN_NEG  = 5'd14;
    localparam logic [4:0] FN_MIN  = 5'd16;
    localparam logic [4:0] FN_MAX  = 5'd17;

    // CMP class
    localparam logic [4:0] FN_EQ   = 5'd1;
    localparam logic [4:0] FN_NE   = 5'd2;
    localparam logic [4:0] FN_LT   = 5'd3;
    localparam logic [4:0] FN_LE   = 5'd4;
    localparam logic [4:0] FN_GT   = 5'd5;
    localparam logic [4:0] FN_GE   = 5'd6;

endpackage

`default_nettype wire

// File: rtl/pe_exec_unit.sv
// ============================================================================
// Module : pe_exec_unit
// Brief  : Combinational execute stage: ARITH, FPU-class and CMP operations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pe_exec_unit
    import pe_core_pkg::*;
(
    input  logic [6:0]        opcode,
    input  logic [4:0]        func,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_c,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_mac;
    logic [DATA_W-1:0] w_quot;
    logic              w_slt;
    logic              w_eq;

    assign w_prod = op_a * op_b;
    assign w_mac  = w_prod + op_c;
    assign w_quot = (op_b == '0) ? {DATA_W{1'b1}} : (op_a / op_b);
    assign w_slt  = $signed(op_a) < $signed(op_b);
    assign w_eq   = (op_a == op_b);

    always_comb begin
        result = '0;
        case (opcode)
            OPC_ARITH: begin
                case (func)
                    FN_ADD:  result = op_a + op_b;
                    FN_SUB:  result = op_a - op_b;
                    FN_MUL:  result = w_prod;
                    FN_DIV:  result = w_quot;
                    FN_MAD:  result = w_mac;
                    FN_AND:  result = op_a & op_b;
                    FN_OR:   result = op_a | op_b;
                    FN_XOR:  result = op_a ^ op_b;
                    FN_SHL:  result = op_a << op_b[4:0];
                    FN_SHR:  result = op_a >> op_b[4:0];
                    default: result = '0;
                endcase
            end
            OPC_FPU: begin
                case (func)
                    FN_FMA:  result = w_mac;
                    FN_RELU: result = op_a[DATA_W-1] ? '0 : op_a;
                    // Negating the most negative value wraps back onto itself.
                    FN_ABS:  result = op_a[DATA_W-1] ? (~op_a + 1'b1) : op_a;
                    FN_NEG:  result = ~op_a + 1'b1;
                    FN_MIN:  result = w_slt ? op_a : op_b;
                    FN_MAX:  result = w_slt ? op_b : op_a;
                    default: result = '0;
                endcase
            end
            OPC_CMP: begin
                case (func)
                    FN_EQ:   result = {{(DATA_W-1){1'b0}}, w_eq};
                    FN_NE:   result = {{(DATA_W-1){1'b0}}, ~w_eq};
                    FN_LT:   result = {{(DATA_W-1){1'b0}}, w_slt};
                    FN_LE:   result = {{(DATA_W-1){1'b0}}, w_slt | w_eq};
                    FN_GT:   result = {{(DATA_W-1){1'b0}}, ~(w_slt | w_eq)};
                    FN_GE:   result = {{(DATA_W-1){1'b0}}, ~w_slt};
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pe_core_v2.sv
// ============================================================================
// Module : pe_core_v2
// Brief  : Two-stage PE datapath: operand capture, then execute and register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pe_core_v2
    import pe_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       opcode_func,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] op3,
    input  logic              valid_in,
    output logic [DATA_W-1:0] result_out,
    output logic              result_valid
);

    logic              r_s1_valid;
    logic [6:0]        r_s1_opcode;
    logic [4:0]        r_s1_func;
    logic [DATA_W-1:0] r_s1_op1;
    logic [DATA_W-1:0] r_s1_op2;
    logic [DATA_W-1:0] r_s1_op3;
    logic [DATA_W-1:0] w_result;
    logic              w_unused_hi;

    assign w_unused_hi = ^opcode_func[31:12];

    // Stage 1: operand and decode capture; data only loads on a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_opcode <= '0;
            r_s1_func   <= '0;
            r_s1_op1    <= '0;
            r_s1_op2    <= '0;
            r_s1_op3    <= '0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_opcode <= opcode_func[11:5];
                r_s1_func   <= opcode_func[4:0];
                r_s1_op1    <= op1;
                r_s1_op2    <= op2;
                r_s1_op3    <= op3;
            end
        end
    end

    pe_exec_unit u_exec (
        .opcode (r_s1_opcode),
        .func   (r_s1_func),
        .op_a   (r_s1_op1),
        .op_b   (r_s1_op2),
        .op_c   (r_s1_op3),
        .result (w_result)
    );

    // Stage 2: result holds its last value while no request is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= r_s1_valid;
            if (r_s1_valid) begin
                result_out <= w_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_core_v2.sv
// ============================================================================
// Module : tb_pe_core_v2
// Brief  : Scoreboard bench for pe_core_v2 with directed vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pe_core_v2;

    logic        clk;
    logic        rst_n;
    logic [31:0] opcode_func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic        valid_in;
    logic [31:0] result_out;
    logic        result_valid;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    pe_core_v2 #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_func  (opcode_func),
        .op1          (op1),
        .op2          (op2),
        .op3          (op3),
        .valid_in     (valid_in),
        .result_out   (result_out),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(posedge clk) begin
        #1;
        while (q.size() != 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no result at cycle %0d", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end
        if (result_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got result %h with nothing pending", result_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_latency"}, cyc, e.cyc);
                check(e.name, result_out, e.val);
            end
        end
    end

    task automatic issue(string nm, logic [6:0] opc, logic [4:0] fn,
                         logic [31:0] a, logic [31:0] b, logic [31:0] c,
                         logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        opcode_func = {20'hABCDE, opc, fn};
        op1 = a;
        op2 = b;
        op3 = c;
        valid_in = 1'b1;
        e.val = exp;
        e.cyc = cyc + 2;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        opcode_func = '0;
        op1 = 32'hDEAD_BEEF;
        op2 = 32'h1234_5678;
        op3 = 32'h0BAD_F00D;
    endtask

    task automatic one(string nm, logic [6:0] opc, logic [4:0] fn,
                       logic [31:0] a, logic [31:0] b, logic [31:0] c,
                       logic [31:0] exp);
        issue(nm, opc, fn, a, b, c, exp);
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        valid_in = 1'b0;
        opcode_func = '0;
        op1 = '0;
        op2 = '0;
        op3 = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", result_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ARITH
        one("add",  7'h01, 5'd1,  32'd10, 32'd20, 32'd0, 32'd30);
        one("sub",  7'h01, 5'd2,  32'd50, 32'd20, 32'd0, 32'd30);
        one("mul",  7'h01, 5'd3,  32'd10, 32'd5,  32'd0, 32'd50);
        one("div",  7'h01, 5'd4,  32'd100, 32'd4, 32'd0, 32'd25);
        one("mad",  7'h01, 5'd5,  32'd10, 32'd5,  32'd3, 32'd53);
        one("and",  7'h01, 5'd9,  32'hFF00, 32'h0F0F, 32'd0, 32'h0F00);
        one("or",   7'h01, 5'd10, 32'hF0F0, 32'h0F0F, 32'd0, 32'hFFFF);
        one("xor",  7'h01, 5'd11, 32'hAAAA, 32'h5555, 32'd0, 32'hFFFF);
        one("shl",  7'h01, 5'd12, 32'd1,  32'd4,  32'd0, 32'd16);
        one("shr",  7'h01, 5'd13, 32'd64, 32'h0000_0023, 32'd0, 32'd8);

        // FPU class
        one("fma",     7'h02, 5'd1,  32'd2, 32'd3, 32'd10, 32'd16);
        one("relu_p",  7'h02, 5'd11, 32'd10, 32'd0, 32'd0, 32'd10);
        one("relu_n",  7'h02, 5'd11, 32'hFFFF_FFF6, 32'd0, 32'd0, 32'd0);
        one("abs",     7'h02, 5'd13, 32'hFFFF_FF9C, 32'd0, 32'd0, 32'd100);
        one("abs_min", 7'h02, 5'd13, 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000);
        one("neg",     7'h02, 5'd14, 32'd50, 32'd0, 32'd0, 32'hFFFF_FFCE);
        one("min",     7'h02, 5'd16, 32'd10, 32'd20, 32'd0, 32'd10);
        one("max",     7'h02, 5'd17, 32'd10, 32'd20, 32'd0, 32'd20);
        one("min_neg", 7'h02, 5'd16, 32'hFFFF_FFFB, 32'd3, 32'd0, 32'hFFFF_FFFB);

        // CMP
        one("eq_t",   7'h10, 5'd1, 32'd10, 32'd10, 32'd0, 32'd1);
        one("eq_f",   7'h10, 5'd1, 32'd10, 32'd20, 32'd0, 32'd0);
        one("ne",     7'h10, 5'd2, 32'd10, 32'd20, 32'd0, 32'd1);
        one("lt",     7'h10, 5'd3, 32'd10, 32'd20, 32'd0, 32'd1);
        one("le",     7'h10, 5'd4, 32'd10, 32'd10, 32'd0, 32'd1);
        one("gt",     7'h10, 5'd5, 32'd20, 32'd10, 32'd0, 32'd1);
        one("ge",     7'h10, 5'd6, 32'd20, 32'd10, 32'd0, 32'd1);
        one("lt_neg", 7'h10, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        one("gt_neg", 7'h10, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        drain();

        // Back-to-back
        issue("b2b_add", 7'h01, 5'd1, 32'd1, 32'd2, 32'd0, 32'd3);
        issue("b2b_sub", 7'h01, 5'd2, 32'd9, 32'd4, 32'd0, 32'd5);
        issue("b2b_mul", 7'h01, 5'd3, 32'd3, 32'd3, 32'd0, 32'd9);
        idle();
        drain();
        @(posedge clk);
        #1;
        check("idle_valid", {31'd0, result_valid}, 32'd0);
        check("idle_hold", result_out, 32'd9);

        // Boundaries
        one("div_zero",  7'h01, 5'd4, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF);
        one("bad_opc",   7'h7F, 5'd1, 32'd7, 32'd8, 32'd9, 32'd0);
        one("bad_func",  7'h01, 5'd31, 32'd7, 32'd8, 32'd9, 32'd0);
        drain();

        // Reset while a request sits in stage 1
        @(negedge clk);
        opcode_func = {20'd0, 7'h01, 5'd1};
        op1 = 32'd5;
        op2 = 32'd6;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_flight_result", result_out, 32'd0);
        check("rst_flight_valid", {31'd0, result_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", {31'd0, result_valid}, 32'd0);
        check("post_rst_result", result_out, 32'd0);

        one("post_rst_add", 7'h01, 5'd1, 32'd100, 32'd23, 32'd0, 32'd123);
        drain();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
